// File: rtl/beat_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : beat_sequencer_if                                    |
// | Description : Console/controller handshake bundle for the beat     |
// |               sequencer (requests in, beats and status out).       |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
interface beat_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             START;
  logic             STEP_MODE;
  logic             SHORT;
  logic             LONG;
  logic             STOP;
  logic [3:1]       W;
  logic             RUN;
  logic             CYC_END;
  logic [CNT_W-1:0] CYC_CNT;
  logic             TIMEOUT;

  // Console / controller side: drives requests, observes beats.
  modport master (
    output START, STEP_MODE, SHORT, LONG, STOP,
    input  W, RUN, CYC_END, CYC_CNT, TIMEOUT
  );

  // Sequencer side.
  modport slave (
    input  START, STEP_MODE, SHORT, LONG, STOP,
    output W, RUN, CYC_END, CYC_CNT, TIMEOUT
  );
endinterface
`default_nettype wire

// File: rtl/beat_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : beat_sequencer                                       |
// | Description : W[3:1] beat generator with run/halt control, single  |
// |               step, machine-cycle counter and optional watchdog.   |
// |               All state advances on the falling edge of T3.        |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module beat_sequencer #(
  parameter int          CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  wire logic           T3,
  input  wire logic           CLR,
  beat_sequencer_if.slave     bus
);

  // Run/halt state, legacy-style one-bit encoding.
  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_run  = 1'b1;

  // Watchdog limit; an out-of-range limit can never be reached by the
  // counter, so the watchdog is simply left disabled in that case.
  localparam logic [63:0]      c_cnt_max = (64'd1 << CNT_W) - 64'd1;
  localparam logic [63:0]      c_max_64  = 64'(MAX_CYCLES);
  localparam logic             c_wd_en   = (c_max_64 != 64'd0) && (c_max_64 <= c_cnt_max);
  localparam logic [CNT_W-1:0] c_wd_lim  = c_max_64[CNT_W-1:0];

  logic [0:0]       r_state;
  logic [3:1]       r_w;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             r_start_d;

  logic             w_go;
  logic             w_cyc_end;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_wd_hit;
  logic             w_halt;

  // Launch edge, final-beat detection, counter increment and halt terms.
  always_comb begin
    w_go      = bus.START & ~r_start_d;
    w_cyc_end = (r_state == c_run) &
                ((r_w[1] & bus.SHORT) | (r_w[2] & ~bus.LONG) | r_w[3]);
    w_cnt_inc = r_cnt + CNT_W'(1);
    w_wd_hit  = c_wd_en & (w_cnt_inc == c_wd_lim);
    w_halt    = bus.STOP | bus.STEP_MODE | w_wd_hit;
  end

  // Beat sequencing, run control, cycle counting and watchdog flag.
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      r_state   <= c_idle;
      r_w       <= 3'b001;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= bus.START;
      case (r_state)
        c_idle: begin
          // Requests are ignored while idle; only a fresh START launches.
          if (w_go) begin
            r_state   <= c_run;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_w       <= 3'b001;
          end
        end
        c_run: begin
          if (w_cyc_end) begin
            // Halt requests only act here, so a cycle is never truncated.
            r_w   <= 3'b001;
            r_cnt <= w_cnt_inc;
            if (w_halt) begin
              r_state <= c_idle;
            end
            if (w_wd_hit) begin
              r_timeout <= 1'b1;
            end
          end else begin
            // Not final: W1 -> W2 or W2 -> W3.
            r_w <= {r_w[2], r_w[1], 1'b0};
          end
        end
        default: begin
          r_state <= c_idle;
          r_w     <= 3'b001;
        end
      endcase
    end
  end

  assign bus.W       = r_w;
  assign bus.RUN     = (r_state == c_run);
  assign bus.CYC_END = w_cyc_end;
  assign bus.CYC_CNT = r_cnt;
  assign bus.TIMEOUT = r_timeout;

endmodule
`default_nettype wire

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Generates the W[3:1] beat (timing-phase) signals and run/halt control that drive the hardwired instruction controller.
- Consumes that controller's SHORT, LONG and STOP requests to shape each machine cycle to 1, 2 or 3 beats.
- Adds console START, single-step mode, a machine-cycle counter and an optional watchdog halt.
- Sits between the console/clock source and the controller; its W output feeds the controller's W input directly.

Parameters:
- CNT_W, 16, width of the machine-cycle counter.
- MAX_CYCLES, 0, watchdog limit in machine cycles per run; 0 disables the watchdog.

Ports:
- T3  input  1  beat clock; all state updates on the falling edge.
- CLR  input  1  asynchronous active-low reset.
- START  input  1  console start level; a run is launched by its 0->1 transition.
- STEP_MODE  input  1  1 = halt after every machine cycle (single step).
- SHORT  input  1  controller request: end the cycle after W1.
- LONG  input  1  controller request: extend the cycle to W3.
- STOP  input  1  controller halt request, sampled only at cycle end.
- W  output  3  one-hot beat, W[1]/W[2]/W[3].
- RUN  output  1  1 while sequencing.
- CYC_END  output  1  combinational; high during the final beat of a cycle while RUN=1.
- CYC_CNT  output  CNT_W  machine cycles completed since the last START launch.
- TIMEOUT  output  1  sticky watchdog-halt flag.

Behaviour:
- Reset (CLR=0, asynchronous): W=3'b001, RUN=0, CYC_CNT=0, TIMEOUT=0, internal start_d=0. Reset mid-cycle aborts immediately with no cycle-end effects.
- start_d is registered from START on every falling edge.
- Launch condition: go = START & ~start_d, evaluated at a falling edge.
- States: IDLE (RUN=0) and RUN (RUN=1).
- IDLE:
  - W holds 3'b001; SHORT, LONG and STOP are ignored.
  - On go: RUN<=1, CYC_CNT<=0, TIMEOUT<=0, W stays 3'b001.
  - The first active beat is W1 of the next T3 period.
- RUN, beat transitions at each falling edge:
  - W1: SHORT=1 -> cycle end, else -> W2. SHORT has priority over LONG in W1.
  - W2: LONG=1 -> W3, else -> cycle end.
  - W3: always cycle end.
  - Cycle end: W<=3'b001 and CYC_CNT<=CYC_CNT+1, wrapping modulo 2^CNT_W.
- CYC_END = RUN & ((W[1]&SHORT) | (W[2]&~LONG) | W[3]).
- Halt at cycle end: RUN<=0 if any of the following holds:
  - STOP=1;
  - STEP_MODE=1;
  - MAX_CYCLES!=0 and the incremented count == MAX_CYCLES. In this case TIMEOUT<=1 as well.
  - STOP, STEP_MODE and watchdog reaching its limit together give one halt; TIMEOUT is set only from the watchdog term.
- Halt timing: STOP and STEP_MODE are not sampled at non-final beats, so a halt never truncates a cycle. A STOP pulse that is low at the final beat has no effect.
- go while RUN=1 is ignored: no counter reset and no restart. START held high launches only once.
- go on the same edge as a halting cycle end: the halt wins. A fresh 0->1 transition of START is required to relaunch.
- TIMEOUT stays 1 through IDLE until the next launch or CLR.
- Watchdog compare uses the full CNT_W count. A MAX_CYCLES value above 2^CNT_W-1 is a configuration error, and the watchdog never fires in that case.
- Outputs W, RUN, CYC_CNT and TIMEOUT are registered and glitch-free. CYC_END is the only combinational output.

Test Plan:
- Reset then idle: CLR=0 mid-W2 -> W=001, RUN=0, CYC_CNT=0 immediately. SHORT/LONG toggled with START=0 for 5 edges -> W stays 001.
- Beat shaping: launch with STEP_MODE=0, STOP=0, then apply cycles with (SHORT=1), (SHORT=0, LONG=0) and (LONG=1) -> W sequence 001 | 001,010 | 001,010,100. CYC_END high on each final beat; CYC_CNT=3.
- Single step: STEP_MODE=1, LONG=1, START pulse -> exactly one W1,W2,W3 cycle, then RUN=0 and CYC_CNT=1. START held high for 4 more edges -> no relaunch. START 0->1 -> one more cycle, CYC_CNT=1 again (reset on launch).
- STOP timing: STOP=1 only during W1 of a 2-beat cycle -> no halt. STOP=1 during W2 with LONG=0 -> RUN=0 after that edge, W=001.
- Watchdog: MAX_CYCLES=4, SHORT=1 -> RUN drops after the 4th cycle end, CYC_CNT=4, TIMEOUT=1. TIMEOUT stays 1 until the next START launch clears it.
- Wrap: CNT_W=2, MAX_CYCLES=0, SHORT=1, 5 cycles -> CYC_CNT sequence 1,2,3,0,1 with RUN held at 1.
